// File: rtl/sha256_ctrl.sv
// sha256_ctrl: pads a big-endian 32-bit word stream into SHA-256 blocks and drives sha256_engine through start/ready/valid.
// Latency: 1 word/cycle in FILL; per block 1 START cycle + engine acceptance + engine run; digest 1 cycle after final engine valid.
// Backpressure: s_ready_o is high only in FILL (from state only); optional engine watchdog under `SHA256_CTRL_TIMEOUT_EN.
module sha256_ctrl #(
    parameter int TIMEOUT_CYC = 512
) (
    input  logic         clk_100mhz,
    input  logic         rstn_i,
    input  logic [31:0]  s_data_i,
    input  logic         s_valid_i,
    input  logic         s_last_i,
    input  logic [1:0]   s_bytes_i,
    output logic         s_ready_o,
    output logic         eng_rstn_o,
    output logic         eng_start_o,
    output logic [511:0] eng_vec_o,
    input  logic         eng_ready_i,
    input  logic         eng_valid_i,
    input  logic [255:0] eng_hash_i,
    output logic [255:0] hash_o,
    output logic         hash_valid_o,
    output logic         busy_o,
    output logic         err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_ENG_RST, S_FILL, S_PAD, S_START, S_WAIT_ACK, S_WAIT_DONE, S_ABORT
    } state_t;

    // What to do once the engine finishes the block currently in flight
    typedef enum logic [1:0] {P_FILL, P_LEN, P_DONE} pend_t;

    state_t           state, next_state;
    pend_t            pend;
    logic [0:15][31:0] blk;        // blk[0] lands in eng_vec_o[511:480]
    logic [3:0]       wi;          // next word slot; holds the last data word index after s_last_i
    logic             mark_full;   // last word was full, so the 0x80 marker goes in the word after wi
    logic [4:0]       marker;      // word index holding the 0x80 marker (16 = next block)
    logic [31:0]      bytecnt;
    logic [2:0]       last_nb;
    logic [31:0]      last_word;
    logic [31:0]      len_hi;
    logic [31:0]      len_lo;
    logic             accept;
    logic             eng_done;
    logic             timeout;
    logic [255:0]     hash_q;
    logic             hash_vld_q;
    logic             err_q;
    logic             eng_rstn_q;

    assign accept   = (state == S_FILL) && s_valid_i;
    assign eng_done = eng_ready_i && eng_valid_i;
    assign marker   = {1'b0, wi} + {4'b0, mark_full};
    // 64-bit bit length = bytecnt * 8, split across words 14 and 15
    assign len_hi   = {29'b0, bytecnt[31:29]};
    assign len_lo   = {bytecnt[28:0], 3'b000};

    // Byte count of the final word and its masked/marked form
    always_comb begin
        last_nb   = 3'd4;
        last_word = s_data_i;
        case (s_bytes_i)
            2'd1: begin
                last_nb   = 3'd1;
                last_word = {s_data_i[31:24], 8'h80, 16'h0000};
            end
            2'd2: begin
                last_nb   = 3'd2;
                last_word = {s_data_i[31:16], 8'h80, 8'h00};
            end
            2'd3: begin
                last_nb   = 3'd3;
                last_word = {s_data_i[31:8], 8'h80};
            end
            default: begin
                last_nb   = 3'd4;
                last_word = s_data_i;
            end
        endcase
    end

`ifdef SHA256_CTRL_TIMEOUT_EN
    logic [31:0] to_cnt;

    // Watchdog: counts cycles spent waiting on the engine
    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            to_cnt <= '0;
        end else if (state == S_WAIT_ACK || state == S_WAIT_DONE) begin
            to_cnt <= to_cnt + 32'd1;
        end else begin
            to_cnt <= '0;
        end
    end

    assign timeout = (state == S_WAIT_ACK || state == S_WAIT_DONE) &&
                     (to_cnt == 32'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign timeout            = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (s_valid_i) next_state = S_ENG_RST;
            S_ENG_RST:   next_state = S_FILL;
            S_FILL: begin
                if (accept) begin
                    if (s_last_i)          next_state = S_PAD;
                    else if (wi == 4'd15)  next_state = S_START;
                end
            end
            S_PAD:       next_state = S_START;
            S_START:     if (eng_ready_i) next_state = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (timeout)           next_state = S_ABORT;
                else if (!eng_ready_i) next_state = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (timeout) begin
                    next_state = S_ABORT;
                end else if (eng_done) begin
                    case (pend)
                        P_FILL:  next_state = S_FILL;
                        P_LEN:   next_state = S_START;
                        default: next_state = S_IDLE;
                    endcase
                end
            end
            S_ABORT:     next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    // Outputs decoded from state (start also waits on engine ready)
    always_comb begin
        s_ready_o   = (state == S_FILL);
        busy_o      = (state != S_IDLE);
        eng_start_o = (state == S_START) && eng_ready_i;
    end

    // Datapath: block assembly, padding, length, digest capture, engine reset pulse
    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            blk        <= '0;
            wi         <= '0;
            mark_full  <= 1'b0;
            bytecnt    <= '0;
            pend       <= P_FILL;
            hash_q     <= '0;
            hash_vld_q <= 1'b0;
            err_q      <= 1'b0;
            eng_rstn_q <= 1'b0;
        end else begin
            eng_rstn_q <= !(next_state == S_ENG_RST || next_state == S_ABORT);
            if (timeout) begin
                err_q <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (s_valid_i) begin
                        hash_q     <= '0;
                        hash_vld_q <= 1'b0;
                        err_q      <= 1'b0;
                        bytecnt    <= '0;
                        wi         <= '0;
                        mark_full  <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        if (s_last_i) begin
                            blk[wi]   <= last_word;
                            bytecnt   <= bytecnt + {29'b0, last_nb};
                            mark_full <= (s_bytes_i == 2'd0);
                        end else begin
                            blk[wi] <= s_data_i;
                            bytecnt <= bytecnt + 32'd4;
                            wi      <= wi + 4'd1;
                            if (wi == 4'd15) pend <= P_FILL;
                        end
                    end
                end
                S_PAD: begin
                    for (int k = 0; k < 16; k++) begin
                        if (mark_full && k == int'(marker)) blk[k] <= 32'h8000_0000;
                        else if (k > int'(wi))              blk[k] <= 32'h0000_0000;
                    end
                    if (marker <= 5'd13) begin
                        blk[14] <= len_hi;
                        blk[15] <= len_lo;
                        pend    <= P_DONE;
                    end else begin
                        pend    <= P_LEN;
                    end
                end
                S_WAIT_DONE: begin
                    if (!timeout && eng_done) begin
                        case (pend)
                            P_FILL: wi <= '0;
                            P_LEN: begin
                                blk <= '0;
                                // A full last word in slot 15 pushes the marker into this block
                                if (marker == 5'd16) blk[0] <= 32'h8000_0000;
                                blk[14] <= len_hi;
                                blk[15] <= len_lo;
                                pend    <= P_DONE;
                            end
                            default: begin
                                hash_q     <= eng_hash_i;
                                hash_vld_q <= 1'b1;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign eng_vec_o    = blk;
    assign eng_rstn_o   = eng_rstn_q;
    assign hash_o       = hash_q;
    assign hash_valid_o = hash_vld_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_sha256_ctrl.sv
`timescale 1ns/1ps
module tb_sha256_ctrl;

    localparam int TO_CYC  = 16;
    localparam int ENG_LAT = 12;

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] H_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] H_56  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rstn;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_last;
    logic [1:0]   s_bytes;
    logic         s_ready;
    logic         eng_rstn;
    logic         eng_start;
    logic [511:0] eng_vec;
    logic         eng_rdy;
    logic         eng_vld;
    logic [255:0] eng_h;
    logic [255:0] hash;
    logic         hash_valid;
    logic         busy;
    logic         err;

    always #5 clk = ~clk;

    sha256_ctrl #(.TIMEOUT_CYC(TO_CYC)) dut (
        .clk_100mhz   (clk),
        .rstn_i       (rstn),
        .s_data_i     (s_data),
        .s_valid_i    (s_valid),
        .s_last_i     (s_last),
        .s_bytes_i    (s_bytes),
        .s_ready_o    (s_ready),
        .eng_rstn_o   (eng_rstn),
        .eng_start_o  (eng_start),
        .eng_vec_o    (eng_vec),
        .eng_ready_i  (eng_rdy),
        .eng_valid_i  (eng_vld),
        .eng_hash_i   (eng_h),
        .hash_o       (hash),
        .hash_valid_o (hash_valid),
        .busy_o       (busy),
        .err_o        (err)
    );

    // ---------------- reference SHA-256 compression ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] b);
        logic [31:0] w [64];
        logic [31:0] a, bb, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, bb, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
            t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
            s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
            t2 = s0 + ((a & bb) ^ (a & c) ^ (bb & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + bb, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    // ---------------- engine stub ----------------
    logic         eng_hang;
    logic [511:0] eng_blk;
    int           eng_cnt;

    always @(posedge clk or negedge eng_rstn) begin
        if (!eng_rstn) begin
            eng_h   <= IV;
            eng_rdy <= 1'b1;
            eng_vld <= 1'b0;
            eng_cnt <= 0;
            eng_blk <= '0;
        end else if (eng_rdy) begin
            if (eng_start) begin
                eng_blk <= eng_vec;
                eng_rdy <= 1'b0;
                eng_vld <= 1'b0;
                eng_cnt <= ENG_LAT;
            end
        end else if (!eng_hang) begin
            if (eng_cnt == 0) begin
                eng_h   <= sha_compress(eng_h, eng_blk);
                eng_rdy <= 1'b1;
                eng_vld <= 1'b1;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    int n_starts = 0;
    int n_eng_rst = 0;
    logic [511:0] exp_blk_q [$];
    logic [255:0] exp_hash_q [$];
    logic hv_prev = 1'b0;
    logic er_prev = 1'b0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every start pulse and every new digest is compared against the queues
    always @(negedge clk) begin
        if (eng_start) begin
            n_starts++;
            chk("block_expected", 512'(exp_blk_q.size() != 0), 512'd1);
            if (exp_blk_q.size() != 0) chk("block", eng_vec, exp_blk_q.pop_front());
        end
        if (hash_valid && !hv_prev) begin
            chk("digest_expected", 512'(exp_hash_q.size() != 0), 512'd1);
            if (exp_hash_q.size() != 0) chk("digest", 512'(hash), 512'(exp_hash_q.pop_front()));
            chk("err_with_digest", 512'(err), 512'd0);
        end
        hv_prev = hash_valid;
        if (!eng_rstn && er_prev) n_eng_rst++;
        er_prev = eng_rstn;
    end

    // ---------------- stimulus ----------------
    logic [31:0] msg [32];

    task automatic send_msg(input int n, input int lastb, input bit gap);
        for (int i = 0; i < n; i++) begin
            int  budget;
            logic acc;
            budget  = 0;
            acc     = 1'b0;
            s_data  = msg[i];
            s_last  = (i == n - 1);
            s_bytes = (i == n - 1) ? 2'(lastb) : 2'd0;
            s_valid = 1'b1;
            do begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk);
                #1;
                budget++;
            end while (!acc && budget < 3000);
            chk("word_accepted", 512'(acc), 512'd1);
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (gap && i != n - 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while ((busy || exp_hash_q.size() != 0 || s_valid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk({name, "_idle"}, 512'(busy), 512'd0);
        chk({name, "_blocks_left"}, 512'(exp_blk_q.size()), 512'd0);
        chk({name, "_digests_left"}, 512'(exp_hash_q.size()), 512'd0);
    endtask

    function automatic logic [511:0] pack16();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = msg[i];
        return b;
    endfunction

    initial begin
        logic [511:0] b1, b2;
        int ns, nr, n;

        rstn = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_bytes = '0; eng_hang = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", 512'(s_ready), 512'd0);
        chk("rst_busy", 512'(busy), 512'd0);
        chk("rst_hash_valid", 512'(hash_valid), 512'd0);
        chk("rst_err", 512'(err), 512'd0);
        chk("rst_eng_rstn", 512'(eng_rstn), 512'd0);
        chk("rst_hash", 512'(hash), 512'd0);
        chk("rst_vec", eng_vec, 512'd0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("eng_rstn_after_reset", 512'(eng_rstn), 512'd1);

        // "abc": single partial word
        msg[0] = 32'h61626300;
        exp_blk_q.push_back({32'h61626380, 448'h0, 32'h00000018});
        exp_hash_q.push_back(H_ABC);
        ns = n_starts;
        send_msg(1, 3, 0);
        wait_quiet("abc");
        chk("abc_starts", 512'(n_starts - ns), 512'd1);

        // 56-byte NIST vector: marker spills into a length-only block
        b1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
              32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071,
              32'h80000000, 32'h00000000};
        b2 = {480'h0, 32'h000001c0};
        for (int i = 0; i < 14; i++) msg[i] = b1[511 - 32*i -: 32];
        exp_blk_q.push_back(b1);
        exp_blk_q.push_back(b2);
        exp_hash_q.push_back(H_56);
        ns = n_starts;
        send_msg(14, 0, 0);
        wait_quiet("msg56");
        chk("msg56_starts", 512'(n_starts - ns), 512'd2);

        // "a" with junk in the unused low bytes
        msg[0] = 32'h61ffeedd;
        b1 = {32'h61800000, 448'h0, 32'h00000008};
        exp_blk_q.push_back(b1);
        exp_hash_q.push_back(sha_compress(IV, b1));
        send_msg(1, 1, 0);
        wait_quiet("one_byte");

        // Generated data words 00010203, 04050607, ...
        for (int i = 0; i < 32; i++) msg[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};

        // 62 bytes, toggling valid: partial last word in slot 15
        b1 = pack16();
        b1[31:0] = 32'h3c3d8000;
        b2 = {480'h0, 32'd496};
        exp_blk_q.push_back(b1);
        exp_blk_q.push_back(b2);
        exp_hash_q.push_back(sha_compress(sha_compress(IV, b1), b2));
        send_msg(16, 2, 1);
        wait_quiet("msg62");

        // 64 bytes: full last word in slot 15, marker opens the next block
        b1 = pack16();
        b2 = {32'h80000000, 448'h0, 32'd512};
        exp_blk_q.push_back(b1);
        exp_blk_q.push_back(b2);
        exp_hash_q.push_back(sha_compress(sha_compress(IV, b1), b2));
        send_msg(16, 0, 0);
        wait_quiet("msg64");

        // 68 bytes: block refill after a full 16-word block
        b1 = pack16();
        b2 = {msg[16], 32'h80000000, 416'h0, 32'd544};
        exp_blk_q.push_back(b1);
        exp_blk_q.push_back(b2);
        exp_hash_q.push_back(sha_compress(sha_compress(IV, b1), b2));
        send_msg(17, 0, 0);
        wait_quiet("msg68");

        // "abc" twice back-to-back with toggling valid: no chaining carry-over
        msg[0] = 32'h61626300;
        for (int i = 0; i < 2; i++) begin
            exp_blk_q.push_back({32'h61626380, 448'h0, 32'h00000018});
            exp_hash_q.push_back(H_ABC);
        end
        nr = n_eng_rst;
        ns = n_starts;
        send_msg(1, 3, 1);
        @(posedge clk);
        #1;
        send_msg(1, 3, 1);
        wait_quiet("b2b");
        chk("b2b_eng_rst_pulses", 512'(n_eng_rst - nr), 512'd2);
        chk("b2b_starts", 512'(n_starts - ns), 512'd2);

`ifdef SHA256_CTRL_TIMEOUT_EN
        // Watchdog: engine accepts the block and never finishes
        eng_hang = 1'b1;
        exp_blk_q.push_back({32'h61626380, 448'h0, 32'h00000018});
        send_msg(1, 3, 0);
        n = 0;
        while (!eng_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wd_start_seen", 512'(eng_start), 512'd1);
        n = 0;
        while (!err && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wd_latency", 512'(n), 512'd17);
        chk("wd_hash_valid", 512'(hash_valid), 512'd0);
        chk("wd_eng_rstn_pulse", 512'(eng_rstn), 512'd0);
        @(negedge clk);
        chk("wd_busy_after", 512'(busy), 512'd0);
        chk("wd_err_sticky", 512'(err), 512'd1);
        eng_hang = 1'b0;
        repeat (3) @(negedge clk);
`else
        chk("err_never_set", 512'(err), 512'd0);
`endif

        // Reset during WAIT_DONE, then a clean "abc"
        msg[0] = 32'h61626300;
        exp_blk_q.push_back({32'h61626380, 448'h0, 32'h00000018});
        ns = n_starts;
        send_msg(1, 3, 0);
        n = 0;
        while (n_starts == ns && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_start_seen", 512'(n_starts - ns), 512'd1);
        repeat (4) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_busy", 512'(busy), 512'd0);
        chk("mid_eng_rstn", 512'(eng_rstn), 512'd0);
        chk("mid_eng_start", 512'(eng_start), 512'd0);
        chk("mid_hash_valid", 512'(hash_valid), 512'd0);
        chk("mid_vec", eng_vec, 512'd0);
        @(negedge clk);
        #2;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_blk_q.push_back({32'h61626380, 448'h0, 32'h00000018});
        exp_hash_q.push_back(H_ABC);
        send_msg(1, 3, 0);
        wait_quiet("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "global timeout");
    end

endmodule
